ksg_ctrl: RTL
=============

KSG_CTRL -- requirements
Module: ksg_ctrl

Interface
REQ-001 SHALL have parameter NUM_WORDS, default 16, meaning the number of 32-bit keystream words per block (fixed 512/32).
REQ-002 SHALL have port clock  in  1  meaning the single clock; all logic is on its posedge.
REQ-003 SHALL have port reset_n  in  1  meaning the asynchronous, active-low reset.
REQ-004 SHALL have port start  in  1  meaning a one-cycle request to begin a job; sampled in IDLE only.
REQ-005 SHALL have port key  in  256  meaning the key; word k is key[32k+31:32k].
REQ-006 SHALL have port nonce  in  96  meaning the nonce; word k is nonce[32k+31:32k].
REQ-007 SHALL have port ctr_init  in  32  meaning the first block counter.
REQ-008 SHALL have port num_blocks  in  16  meaning the number of blocks in the job.
REQ-009 SHALL have ports ksg_data_in out 32, ksg_valid_in out 1 and ksg_ready_in in 1, meaning the state-load stream to the keystream generator.
REQ-010 SHALL have ports ksg_output_key in 512, ksg_valid_out in 1, ksg_ready_out out 1 and ksg_done_out out 1, meaning block result, result valid, controller ready, and block consumed.
REQ-011 SHALL have ports ks_data out 32, ks_valid out 1 and ks_ready in 1, meaning the downstream keystream word stream.
REQ-012 SHALL have ports busy out 1, done out 1 and err out 1, meaning job active, one-cycle job-complete pulse, and sticky counter-overflow flag.

Function
REQ-013 SHALL implement states IDLE, LOAD, WAIT and DRAIN, with busy=1 in every state except IDLE.
REQ-014 SHALL, in IDLE with start=1 and num_blocks!=0, capture key, nonce, ctr_init and num_blocks into internal registers and enter LOAD on the next edge.
REQ-015 SHALL, in IDLE with start=1 and num_blocks==0, stay in IDLE and pulse done for one cycle, with no KSG traffic.
REQ-016 SHALL ignore start in every state except IDLE; a job is never restarted mid-operation.
REQ-017 SHALL in LOAD drive ksg_valid_in=1 and send 12 words in this order: key words 0..7, then the current block counter, then nonce words 0..2.
REQ-018 SHALL advance the load word index (4 bits, 0..11) only on a cycle with ksg_valid_in and ksg_ready_in both high, and SHALL hold ksg_data_in stable while it is stalled.
REQ-019 SHALL enter WAIT after word 11 is accepted, with ksg_valid_in=0 in that following cycle.
REQ-020 SHALL in WAIT drive ksg_ready_out=1; ksg_ready_out SHALL be 0 in every other state.
REQ-021 SHALL, in WAIT with ksg_valid_out=1, register ksg_output_key into a 512-bit buffer and enter DRAIN.
REQ-022 SHALL in DRAIN drive ks_valid=1 and ks_data = buffer[32i+31:32i] for i=0..15, advancing i only on ks_valid and ks_ready both high, with data held while stalled.
REQ-023 SHALL pulse ksg_done_out for one cycle in the cycle after word 15 is accepted.
REQ-024 SHALL, after word 15 is accepted, decrement the remaining-block count and increment the block counter modulo 2^32.
REQ-025 SHALL then enter LOAD if the remaining-block count is nonzero; otherwise it SHALL enter IDLE and pulse done for one cycle.
REQ-026 SHALL produce first-word latency as follows: start at cycle N gives ksg_valid_in=1 with key word 0 at cycle N+1.
REQ-027 SHALL NOT combinationally depend any output on ks_ready, ksg_ready_in or ksg_valid_out.

Reset
REQ-028 SHALL, on reset_n=0, immediately set the state to IDLE and every output to 0, clear all counters, indices and the buffer, and clear err.
REQ-029 SHALL, when reset asserts mid-job (any state), abandon the job with no done pulse; after release, only a new start is acted on.

Configuration
REQ-030 SHALL, with KSG_CTRL_CTR_OVF_CHECK_EN defined, refuse a block whose counter would wrap from 0xFFFFFFFF to 0x00000000 with blocks remaining: it SHALL set err=1, pulse done, return to IDLE, and issue no further KSG load; err SHALL clear on the next accepted start or on reset.
REQ-031 SHALL, without KSG_CTRL_CTR_OVF_CHECK_EN, wrap the counter silently, tie err to 0, and omit all overflow logic.

Verification
REQ-032 SHALL cover this scenario: key bytes 00..1f (word0=0x03020100), nonce words {0x09000000,0x4a000000,0x00000000}, ctr_init=1, num_blocks=1, with an ideal KSG model -> ks_data word0=0xe4e7f110, then done one cycle after word 15.
REQ-033 SHALL cover this scenario: num_blocks=3, ctr_init=7 -> the counter word in the three loads is 7, 8, 9, there are 48 ks words, and done pulses once.
REQ-034 SHALL cover this scenario: random ks_ready and ksg_ready_in backpressure (50%) -> no word lost or duplicated, and data stays stable while stalled.
REQ-035 SHALL cover this scenario: start with num_blocks=0 -> done at N+1 and ksg_valid_in never high.
REQ-036 SHALL cover this scenario: reset_n low during DRAIN word 5 -> all outputs 0 at once, no done, and a new start works normally.
REQ-037 SHALL cover this scenario: ctr_init=0xFFFFFFFF, num_blocks=2 -> with the macro, one block then err=1 and done; without it, the second counter word is 0x00000000.

Source files
------------

// File: rtl/ksg_ctrl.sv
// ksg_ctrl: loads key/counter/nonce into a keystream generator and streams each 512-bit block out as 32-bit words.
// Define KSG_CTRL_CTR_OVF_CHECK_EN to refuse a block counter wrap and flag it on err.
module ksg_ctrl #(
  parameter int NUM_WORDS = 16
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         start,
  input  logic [255:0] key,
  input  logic [95:0]  nonce,
  input  logic [31:0]  ctr_init,
  input  logic [15:0]  num_blocks,
  output logic [31:0]  ksg_data_in,
  output logic         ksg_valid_in,
  input  logic         ksg_ready_in,
  input  logic [511:0] ksg_output_key,
  input  logic         ksg_valid_out,
  output logic         ksg_ready_out,
  output logic         ksg_done_out,
  output logic [31:0]  ks_data,
  output logic         ks_valid,
  input  logic         ks_ready,
  output logic         busy,
  output logic         done,
  output logic         err
);
  typedef enum logic [1:0] {IDLE, LOAD, WAIT, DRAIN} state_t;
  state_t state, state_next;
  logic [255:0] key_r;
  logic [95:0]  nonce_r;
  logic [31:0]  ctr;
  logic [15:0]  remaining;
  logic [3:0]   load_idx, drain_idx;
  logic [511:0] block_buf;
  logic load_fire, load_last, drain_fire, drain_last, ovf;
  assign load_fire  = state == LOAD && ksg_ready_in;
  assign load_last  = load_fire && load_idx == 4'd11;
  assign drain_fire = state == DRAIN && ks_ready;
  assign drain_last = drain_fire && drain_idx == 4'(NUM_WORDS - 1);
  assign busy          = state != IDLE;
  assign ksg_valid_in  = state == LOAD;
  assign ksg_ready_out = state == WAIT;
  assign ks_valid      = state == DRAIN;
  assign ks_data       = block_buf[{drain_idx, 5'b0} +: 32];
  // load order: key words 0..7, block counter, nonce words 0..2
  assign ksg_data_in = load_idx < 4'd8   ? key_r[{load_idx[2:0], 5'b0} +: 32] :
                       load_idx == 4'd8  ? ctr :
                       load_idx == 4'd9  ? nonce_r[31:0] :
                       load_idx == 4'd10 ? nonce_r[63:32] : nonce_r[95:64];
`ifdef KSG_CTRL_CTR_OVF_CHECK_EN
  assign ovf = ctr == '1 && remaining != 16'd1;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      err <= 1'b0;
    else if (state == IDLE && start)
      err <= 1'b0;
    else if (drain_last && ovf)
      err <= 1'b1;
  end
`else
  assign ovf = 1'b0;
  assign err = 1'b0;
`endif
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = start && num_blocks != '0 ? LOAD : IDLE;
      LOAD:    state_next = load_last ? WAIT : LOAD;
      WAIT:    state_next = ksg_valid_out ? DRAIN : WAIT;
      DRAIN:   state_next = !drain_last ? DRAIN : (remaining == 16'd1 || ovf) ? IDLE : LOAD;
      default: state_next = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      key_r        <= '0;
      nonce_r      <= '0;
      ctr          <= '0;
      remaining    <= '0;
      load_idx     <= '0;
      drain_idx    <= '0;
      block_buf    <= '0;
      done         <= 1'b0;
      ksg_done_out <= 1'b0;
    end else begin
      state        <= state_next;
      done         <= 1'b0;
      ksg_done_out <= drain_last;
      if (state == IDLE && start) begin
        done <= num_blocks == '0;
        if (num_blocks != '0) begin
          key_r     <= key;
          nonce_r   <= nonce;
          ctr       <= ctr_init;
          remaining <= num_blocks;
        end
      end
      if (load_fire)
        load_idx <= load_last ? '0 : load_idx + 4'd1;
      if (state == WAIT && ksg_valid_out)
        block_buf <= ksg_output_key;
      if (drain_fire)
        drain_idx <= drain_last ? '0 : drain_idx + 4'd1;
      if (drain_last) begin
        remaining <= remaining - 16'd1;
        ctr       <= ctr + 32'd1;
        done      <= remaining == 16'd1 || ovf;
      end
    end
  end
endmodule
